// File: rtl/mm_csr_master.sv
// mm_csr_master: single-outstanding command initiator for the example-design
// CSR slave. A host hands over one write or read at a time. The block issues a
// one-cycle strobe to the slave, waits a bounded time for read data, and then
// presents a response that is held until the host takes it.
//
// Handshake rules on both host channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge. The receiver may raise or lower ready freely. On this
// block cmd_ready is high only in IDLE. rsp_valid stays high with rsp_* frozen
// until rsp_ready is seen.
module mm_csr_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16   // legal range 2..255
) (
    input  logic              clk,
    input  logic              rst,
    // host command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // host response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // CSR slave side
    output logic [ADDR_W-1:0] csr_wr_rd_addr,
    output logic              csr_wr_en,
    output logic              csr_rd_en,
    output logic [DATA_W-1:0] csr_wr_data,
    input  logic [DATA_W-1:0] csr_rd_datain,
    input  logic              csr_rd_dvalid,
    // status
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        WAIT_RD = 3'd3,
        RESP    = 3'd4
    } state_t;

    // The timer counts WAIT_RD cycles from 0. Reaching this value ends the read.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    // Registered state and outputs (_q), with their next values (_n)
    state_t            state_q, state_n;
    logic [7:0]        timer_q, timer_n;
    logic [7:0]        tcnt_q, tcnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              wr_en_q, wr_en_n;
    logic              rd_en_q, rd_en_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic              rsp_write_q, rsp_write_n;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_n;
    logic              rsp_err_q, rsp_err_n;

    // Next-state and next-output logic. Every register holds by default.
    // The strobes default to 0, which keeps each of them to a single cycle.
    always_comb begin
        state_n     = state_q;
        timer_n     = timer_q;
        tcnt_n      = tcnt_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        wr_en_n     = 1'b0;
        rd_en_n     = 1'b0;
        rsp_valid_n = rsp_valid_q;
        rsp_write_n = rsp_write_q;
        rsp_rdata_n = rsp_rdata_q;
        rsp_err_n   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Accept: the address and data stay latched until the next accept.
                    addr_n      = cmd_addr;
                    wdata_n     = cmd_wdata;
                    rsp_write_n = cmd_write;
                    if (cmd_write) begin
                        state_n = WRITE;
                        wr_en_n = 1'b1;
                    end else begin
                        state_n = READ;
                        rd_en_n = 1'b1;
                    end
                end
            end

            WRITE: begin
                // The write strobe is on in this cycle. A write cannot fail.
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_rdata_n = '0;
            end

            READ: begin
                // The read strobe is on in this cycle. Start the wait from zero.
                state_n = WAIT_RD;
                timer_n = 8'd0;
            end

            WAIT_RD: begin
                if (csr_rd_dvalid) begin
                    // Data that arrives on the last timer cycle still wins.
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_rdata_n = csr_rd_datain;
                end else if (timer_q == TIMER_LAST) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_n = tcnt_q + 8'd1;
                    end
                end else begin
                    timer_n = timer_q + 8'd1;
                end
            end

            RESP: begin
                // The response is frozen until the host takes it.
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end

            default: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears everything and drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= 8'd0;
            tcnt_q      <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            timer_q     <= timer_n;
            tcnt_q      <= tcnt_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            wr_en_q     <= wr_en_n;
            rd_en_q     <= rd_en_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_write_q <= rsp_write_n;
            rsp_rdata_q <= rsp_rdata_n;
            rsp_err_q   <= rsp_err_n;
        end
    end

    // cmd_ready is gated by rst so that the host sees no acceptance during reset.
    assign cmd_ready      = (state_q == IDLE) && !rst;
    assign busy           = (state_q != IDLE);
    assign timeout_cnt    = tcnt_q;
    assign csr_wr_rd_addr = addr_q;
    assign csr_wr_data    = wdata_q;
    assign csr_wr_en      = wr_en_q;
    assign csr_rd_en      = rd_en_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_write      = rsp_write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_mm_csr_master.sv
// Testbench for mm_csr_master. A behavioural CSR slave answers reads below
// 0x4000 after a programmable delay. Expected responses go into a queue when a
// command is issued and are popped when the response appears.
module tb_mm_csr_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] csr_wr_rd_addr;
    logic        csr_wr_en;
    logic        csr_rd_en;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_rd_datain;
    logic        csr_rd_dvalid;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Expected responses: {rsp_write, rsp_err, rsp_rdata}
    logic [33:0] exp_q[$];

    // Slave model state
    logic [31:0] mem [logic [15:0]];
    logic        slave_en   = 1'b1;
    int          slave_lat  = 1;
    int          sl_cnt     = 0;
    logic [15:0] sl_addr    = '0;
    logic        slave_dv   = 1'b0;
    logic [31:0] slave_data = '0;
    logic        stray_dv   = 1'b0;
    logic [31:0] stray_data = '0;
    logic        prev_wr    = 1'b0;
    logic        prev_rd    = 1'b0;

    assign csr_rd_dvalid = slave_dv | stray_dv;
    assign csr_rd_datain = slave_dv ? slave_data : stray_data;

    mm_csr_master #(
        .ADDR_W (16),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .csr_wr_rd_addr(csr_wr_rd_addr),
        .csr_wr_en     (csr_wr_en),
        .csr_rd_en     (csr_rd_en),
        .csr_wr_data   (csr_wr_data),
        .csr_rd_datain (csr_rd_datain),
        .csr_rd_dvalid (csr_rd_dvalid),
        .busy          (busy),
        .timeout_cnt   (timeout_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for a single cycle and queue its expected response.
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [33:0] exp);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        exp_q.push_back(exp);
        tick();
        // Scramble the payload after acceptance. The DUT must keep its latched copy.
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_wdata = $urandom;
    endtask

    // Wait for the response, check its latency and payload against the queue,
    // optionally stall rsp_ready, then complete the handshake.
    task automatic collect(input string tag, input int exp_lat, input int stall);
        int lat = 1;
        logic [33:0] exp;
        rsp_ready = (stall == 0);
        while (rsp_valid !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_rsp"}, {rsp_write, rsp_err, rsp_rdata}, exp);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_rsp"}, {rsp_write, rsp_err, rsp_rdata}, exp);
            check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check({tag, "_rsp_done"}, rsp_valid, 0);
        check({tag, "_idle_ready"}, cmd_ready, 1);
    endtask

    // ---------------- slave model ----------------
    always @(posedge clk) begin
        #1;
        slave_dv = 1'b0;
        if (sl_cnt > 0) begin
            sl_cnt--;
            if (sl_cnt == 0) begin
                slave_dv   = 1'b1;
                slave_data = mem.exists(sl_addr) ? mem[sl_addr] : 32'h0;
            end
        end
        if (csr_rd_en === 1'b1 && slave_en && csr_wr_rd_addr < 16'h4000) begin
            sl_cnt  = slave_lat;
            sl_addr = csr_wr_rd_addr;
        end
        if (csr_wr_en === 1'b1) begin
            mem[csr_wr_rd_addr] = csr_wr_data;
        end
    end

    // ---------------- strobe monitor ----------------
    always @(posedge clk) begin
        #1;
        check("strobe_exclusive", csr_wr_en & csr_rd_en, 0);
        check("wr_en_single", csr_wr_en & prev_wr, 0);
        check("rd_en_single", csr_rd_en & prev_rd, 0);
        prev_wr = csr_wr_en;
        prev_rd = csr_rd_en;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int exp_cnt;
        logic [15:0] a;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {csr_wr_en, csr_rd_en}, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        check("rst_addr_data", {csr_wr_rd_addr, csr_wr_data}, 0);
        check("rst_rsp", {rsp_write, rsp_err, rsp_rdata}, 0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        // 1: write 0x1004 = 0x12345678
        issue(1'b1, 16'h1004, 32'h12345678, {1'b1, 1'b0, 32'h0});
        check("t1_wr_en", csr_wr_en, 1);
        check("t1_rd_en", csr_rd_en, 0);
        check("t1_addr", csr_wr_rd_addr, 16'h1004);
        check("t1_wdata", csr_wr_data, 32'h12345678);
        check("t1_busy", busy, 1);
        collect("t1", 2, 0);
        check("t1_addr_hold", csr_wr_rd_addr, 16'h1004);
        check("t1_wdata_hold", csr_wr_data, 32'h12345678);

        // 2: read back 0x1004, slave answers one cycle after rd_en
        issue(1'b0, 16'h1004, 32'h0, {1'b0, 1'b0, 32'h12345678});
        check("t2_rd_en", csr_rd_en, 1);
        check("t2_wr_en", csr_wr_en, 0);
        check("t2_addr", csr_wr_rd_addr, 16'h1004);
        collect("t2", 3, 0);

        // 3: unmapped read times out after 16 cycles in WAIT_RD
        issue(1'b0, 16'h5000, 32'h0, {1'b0, 1'b1, 32'h0});
        collect("t3", 18, 0);
        check("t3_timeout_cnt", timeout_cnt, 1);

        // 4: response stalled for 5 cycles
        issue(1'b1, 16'h2000, 32'hA5A50F0F, {1'b1, 1'b0, 32'h0});
        collect("t4", 2, 5);
        check("t4_busy", busy, 0);

        // Data on the last timer cycle wins over the timeout
        slave_lat = 16;
        issue(1'b0, 16'h2000, 32'h0, {1'b0, 1'b0, 32'hA5A50F0F});
        collect("edge_data_wins", 18, 0);
        check("edge_data_wins_cnt", timeout_cnt, 1);

        // Data one cycle too late: timeout, and the late dvalid lands in RESP
        slave_lat = 17;
        issue(1'b0, 16'h2000, 32'h0, {1'b0, 1'b1, 32'h0});
        collect("edge_late", 18, 0);
        check("edge_late_cnt", timeout_cnt, 2);
        check("edge_late_rdata", rsp_rdata, 32'h0);
        check("edge_late_err", rsp_err, 1);
        slave_lat = 1;

        // 5: reset while in WAIT_RD, then a late dvalid, then a normal read
        slave_en = 1'b0;
        issue(1'b0, 16'h1004, 32'h0, {1'b0, 1'b0, 32'h12345678});
        tick();
        check("t5_busy_wait", busy, 1);
        check("t5_no_rsp", rsp_valid, 0);
        rst = 1'b1;
        tick();
        void'(exp_q.pop_back());
        check("t5_rst_cmd_ready", cmd_ready, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rsp_valid", rsp_valid, 0);
        check("t5_rst_rsp", {rsp_write, rsp_err, rsp_rdata}, 0);
        check("t5_rst_csr", {csr_wr_en, csr_rd_en, csr_wr_rd_addr, csr_wr_data}, 0);
        check("t5_rst_timeout_cnt", timeout_cnt, 0);
        rst        = 1'b0;
        stray_dv   = 1'b1;
        stray_data = 32'hDEADBEEF;
        tick();
        stray_dv = 1'b0;
        check("t5_late_rsp_valid", rsp_valid, 0);
        check("t5_late_rdata", rsp_rdata, 0);
        check("t5_late_busy", busy, 0);
        slave_en = 1'b1;
        issue(1'b0, 16'h1004, 32'h0, {1'b0, 1'b0, 32'h12345678});
        collect("t5_read", 3, 0);

        // 6a: stray dvalid pulses in IDLE change nothing
        for (int k = 0; k < 3; k++) begin
            stray_dv   = 1'b1;
            stray_data = $urandom;
            tick();
            check("t6_stray_rsp_valid", rsp_valid, 0);
            check("t6_stray_rsp", {rsp_write, rsp_err, rsp_rdata}, {1'b0, 1'b0, 32'h12345678});
            check("t6_stray_busy", busy, 0);
            check("t6_stray_cnt", timeout_cnt, 0);
        end
        stray_dv = 1'b0;

        // 6b: 256 timed-out reads, counter saturates at 255
        exp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            a = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
            issue(1'b0, a, 32'h0, {1'b0, 1'b1, 32'h0});
            collect("t6_timeout", 18, 0);
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            check("t6_timeout_cnt", timeout_cnt, 64'(exp_cnt));
        end
        check("t6_saturated", timeout_cnt, 255);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
